// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_D = 2'd1,
    ST_BUSY_I = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and mem_system.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          i_stall;
  // Data port
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_dump;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;
  logic          err;
  // mem_system side
  logic          m_rd;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_dump;
  logic [DW-1:0] m_rdata;
  logic          m_done;
  logic          m_stall;
  logic          m_err;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, d_dump,
           m_rdata, m_done, m_stall, m_err,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, err,
           m_rd, m_wr, m_addr, m_wdata, m_dump
  );

  // Requester / memory-model view
  modport master (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, d_dump,
           m_rdata, m_done, m_stall, m_err,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, err,
           m_rd, m_wr, m_addr, m_wdata, m_dump
  );
endinterface

// File: rtl/mem_port_arbiter_cmd_latch.sv
// Enable-loaded holding register for the granted memory command.
module arb_cmd_latch #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          rd_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          rd_o,
  output logic          wr_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o
);

  logic          rd_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  // Capture the winner's command on the grant cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load_i) begin
      rd_q    <= rd_i;
      wr_q    <= wr_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  assign rd_o    = rd_q;
  assign wr_o    = wr_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one mem_system between the fetch (I) and memory-stage (D) ports.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int AW            = 16,
  parameter int DW            = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  state_e        state_q;
  logic          abandoned_q;
  logic          last_grant_q;
  logic          err_q;

  logic          d_pend;
  logic          grant_d;
  logic          grant_i;
  logic          busy;
  logic          owner_req;
  logic          done_fire;

  logic          cmd_rd;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          lat_rd;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // Memory stall is informational only; completion is signalled by Done.
  logic          unused_m_stall;
  assign unused_m_stall = bus.m_stall;

  assign d_pend  = bus.d_rd | bus.d_wr;
  // D wins a tie under fixed priority, or when I was served last.
  assign grant_d = (state_q == ST_IDLE) && d_pend &&
                   (!bus.i_req || (DATA_PRIORITY != 0) || (last_grant_q == GRANT_I));
  assign grant_i = (state_q == ST_IDLE) && bus.i_req && !grant_d;

  assign busy      = (state_q == ST_BUSY_D) || (state_q == ST_BUSY_I);
  assign owner_req = (state_q == ST_BUSY_D) ? d_pend : bus.i_req;
  assign done_fire = busy && bus.m_done && !abandoned_q;

  // Select the winning command; a rd+wr conflict resolves to a write.
  always_comb begin
    cmd_rd    = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    if (grant_d) begin
      cmd_rd    = bus.d_rd & ~bus.d_wr;
      cmd_wr    = bus.d_wr;
      cmd_addr  = bus.d_addr;
      cmd_wdata = bus.d_wdata;
    end else if (grant_i) begin
      cmd_rd    = 1'b1;
      cmd_addr  = bus.i_addr;
    end
  end

  arb_cmd_latch #(
    .AW (AW),
    .DW (DW)
  ) u_cmd_latch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant_d | grant_i),
    .rd_i    (cmd_rd),
    .wr_i    (cmd_wr),
    .addr_i  (cmd_addr),
    .wdata_i (cmd_wdata),
    .rd_o    (lat_rd),
    .wr_o    (lat_wr),
    .addr_o  (lat_addr),
    .wdata_o (lat_wdata)
  );

  // Drive mem_system: live command on the issue cycle, latched while busy, idle in the gap.
  always_comb begin
    bus.m_rd    = 1'b0;
    bus.m_wr    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        bus.m_rd    = cmd_rd;
        bus.m_wr    = cmd_wr;
        bus.m_addr  = cmd_addr;
        bus.m_wdata = cmd_wdata;
      end
      ST_BUSY_D, ST_BUSY_I: begin
        bus.m_rd    = lat_rd;
        bus.m_wr    = lat_wr;
        bus.m_addr  = lat_addr;
        bus.m_wdata = lat_wdata;
      end
      default: ;
    endcase
  end

  assign bus.m_dump  = bus.d_dump;
  assign bus.i_done  = done_fire && (state_q == ST_BUSY_I);
  assign bus.d_done  = done_fire && (state_q == ST_BUSY_D);
  assign bus.i_rdata = bus.i_done ? bus.m_rdata : '0;
  assign bus.d_rdata = bus.d_done ? bus.m_rdata : '0;
  assign bus.i_stall = bus.i_req & ~bus.i_done;
  assign bus.d_stall = d_pend & ~bus.d_done;
  assign bus.err     = err_q;

  // Arbitration FSM with abandon tracking, grant history and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      abandoned_q  <= 1'b0;
      last_grant_q <= GRANT_I;
      err_q        <= 1'b0;
    end else begin
      err_q <= err_q | bus.m_err | (bus.d_rd & bus.d_wr);
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            state_q      <= ST_BUSY_D;
            last_grant_q <= GRANT_D;
          end else if (grant_i) begin
            state_q      <= ST_BUSY_I;
            last_grant_q <= GRANT_I;
          end
        end
        ST_BUSY_D, ST_BUSY_I: begin
          if (bus.m_done) begin
            state_q     <= ST_GAP;
            abandoned_q <= 1'b0;
          end else if (!owner_req) begin
            abandoned_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority and round-robin instances.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus_p ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) bus_r ();

  mem_port_arbiter #(.DATA_PRIORITY(1), .AW(16), .DW(16)) dut_p (
    .clk (clk),
    .rst (rst),
    .bus (bus_p)
  );

  mem_port_arbiter #(.DATA_PRIORITY(0), .AW(16), .DW(16)) dut_r (
    .clk (clk),
    .rst (rst),
    .bus (bus_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs before sampling.
  task automatic settle();
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_inputs();
    bus_p.i_req = 0; bus_p.i_addr = '0; bus_p.d_rd = 0; bus_p.d_wr = 0;
    bus_p.d_addr = '0; bus_p.d_wdata = '0; bus_p.d_dump = 0;
    bus_p.m_rdata = '0; bus_p.m_done = 0; bus_p.m_stall = 0; bus_p.m_err = 0;
    bus_r.i_req = 0; bus_r.i_addr = '0; bus_r.d_rd = 0; bus_r.d_wr = 0;
    bus_r.d_addr = '0; bus_r.d_wdata = '0; bus_r.d_dump = 0;
    bus_r.m_rdata = '0; bus_r.m_done = 0; bus_r.m_stall = 0; bus_r.m_err = 0;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    apply_reset();
    settle();
    if (bus_p.m_rd !== 1'b0)    begin chk_cnt++; $display("FAIL rst_m_rd: got %b expected 0", bus_p.m_rd); end
    else begin chk_cnt++; pass_cnt++; end
    if (bus_p.m_wr !== 1'b0)    begin chk_cnt++; $display("FAIL rst_m_wr: got %b expected 0", bus_p.m_wr); end
    else begin chk_cnt++; pass_cnt++; end
    if (bus_p.m_addr !== 16'h0) begin chk_cnt++; $display("FAIL rst_m_addr: got %h expected 0", bus_p.m_addr); end
    else begin chk_cnt++; pass_cnt++; end
    if (bus_p.err !== 1'b0)     begin chk_cnt++; $display("FAIL rst_err: got %b expected 0", bus_p.err); end
    else begin chk_cnt++; pass_cnt++; end
    if (bus_r.i_stall !== 1'b0 || bus_r.d_stall !== 1'b0) begin
      chk_cnt++; $display("FAIL rst_stalls: got %b%b expected 00", bus_r.i_stall, bus_r.d_stall);
    end else begin chk_cnt++; pass_cnt++; end
    tick();
    bus_p.d_dump = 1;
    settle();
    if (bus_p.m_dump !== 1'b1) begin chk_cnt++; $display("FAIL dump_pass: got %b expected 1", bus_p.m_dump); end
    else begin chk_cnt++; pass_cnt++; end
    bus_p.d_dump = 0;
  endtask

  task automatic test_fetch_alone();
    tick();
    bus_p.i_req = 1; bus_p.i_addr = 16'h0010;
    settle();
    chk("fetch_c0_m_rd", 32'(bus_p.m_rd), 32'd1);
    chk("fetch_c0_m_addr", 32'(bus_p.m_addr), 32'h0010);
    chk("fetch_c0_i_stall", 32'(bus_p.i_stall), 32'd1);
    tick();
    settle();
    chk("fetch_c1_m_addr", 32'(bus_p.m_addr), 32'h0010);
    chk("fetch_c1_i_stall", 32'(bus_p.i_stall), 32'd1);
    tick();
    bus_p.m_done = 1; bus_p.m_rdata = 16'hBEEF;
    settle();
    chk("fetch_c2_i_done", 32'(bus_p.i_done), 32'd1);
    chk("fetch_c2_i_rdata", 32'(bus_p.i_rdata), 32'hBEEF);
    chk("fetch_c2_i_stall", 32'(bus_p.i_stall), 32'd0);
    tick();
    bus_p.m_done = 0; bus_p.m_rdata = '0; bus_p.i_req = 0;
    settle();
    chk("fetch_c3_gap_m_rd", 32'(bus_p.m_rd), 32'd0);
  endtask

  task automatic test_priority();
    tick();
    bus_p.d_wr = 1; bus_p.d_addr = 16'h0100; bus_p.d_wdata = 16'h1234;
    bus_p.i_req = 1; bus_p.i_addr = 16'h0002;
    settle();
    chk("prio_c0_m_wr", 32'(bus_p.m_wr), 32'd1);
    chk("prio_c0_m_rd", 32'(bus_p.m_rd), 32'd0);
    chk("prio_c0_m_wdata", 32'(bus_p.m_wdata), 32'h1234);
    chk("prio_c0_m_addr", 32'(bus_p.m_addr), 32'h0100);
    tick();
    bus_p.m_done = 1; bus_p.m_rdata = 16'hAAAA;
    settle();
    chk("prio_c1_d_done", 32'(bus_p.d_done), 32'd1);
    chk("prio_c1_i_done", 32'(bus_p.i_done), 32'd0);
    chk("prio_c1_i_stall", 32'(bus_p.i_stall), 32'd1);
    tick();
    bus_p.m_done = 0; bus_p.m_rdata = '0; bus_p.d_wr = 0;
    settle();
    chk("prio_c2_gap_m_rd", 32'(bus_p.m_rd), 32'd0);
    chk("prio_c2_i_stall", 32'(bus_p.i_stall), 32'd1);
    tick();
    settle();
    chk("prio_c3_m_rd", 32'(bus_p.m_rd), 32'd1);
    chk("prio_c3_m_addr", 32'(bus_p.m_addr), 32'h0002);
    tick();
    bus_p.m_done = 1; bus_p.m_rdata = 16'h5555;
    settle();
    chk("prio_c4_i_done", 32'(bus_p.i_done), 32'd1);
    chk("prio_c4_i_rdata", 32'(bus_p.i_rdata), 32'h5555);
    tick();
    bus_p.m_done = 0; bus_p.m_rdata = '0; bus_p.i_req = 0;
  endtask

  task automatic test_abandon();
    tick();
    bus_p.i_req = 1; bus_p.i_addr = 16'h0004;
    settle();
    chk("abn_c0_m_addr", 32'(bus_p.m_addr), 32'h0004);
    tick();
    bus_p.i_req = 0; bus_p.i_addr = 16'h0FFF;
    settle();
    chk("abn_c1_m_rd", 32'(bus_p.m_rd), 32'd1);
    tick();
    settle();
    chk("abn_c2_m_addr", 32'(bus_p.m_addr), 32'h0004);
    tick();
    bus_p.m_done = 1; bus_p.m_rdata = 16'h1111;
    settle();
    chk("abn_c3_i_done", 32'(bus_p.i_done), 32'd0);
    chk("abn_c3_i_rdata", 32'(bus_p.i_rdata), 32'h0000);
    chk("abn_c3_m_addr", 32'(bus_p.m_addr), 32'h0004);
    tick();
    bus_p.m_done = 0; bus_p.m_rdata = '0;
    bus_p.i_req = 1; bus_p.i_addr = 16'h0006;
    settle();
    chk("abn_c4_gap_m_rd", 32'(bus_p.m_rd), 32'd0);
    tick();
    settle();
    chk("abn_c5_idle_m_rd", 32'(bus_p.m_rd), 32'd1);
    chk("abn_c5_idle_m_addr", 32'(bus_p.m_addr), 32'h0006);
    tick();
    bus_p.m_done = 1; bus_p.m_rdata = 16'h2222;
    settle();
    chk("abn_c6_i_done", 32'(bus_p.i_done), 32'd1);
    tick();
    bus_p.m_done = 0; bus_p.m_rdata = '0; bus_p.i_req = 0;
  endtask

  task automatic test_conflict();
    tick();
    bus_p.d_rd = 1; bus_p.d_wr = 1; bus_p.d_addr = 16'h0200; bus_p.d_wdata = 16'h0ABC;
    settle();
    chk("cfl_m_wr", 32'(bus_p.m_wr), 32'd1);
    chk("cfl_m_rd", 32'(bus_p.m_rd), 32'd0);
    chk("cfl_err_before", 32'(bus_p.err), 32'd0);
    tick();
    bus_p.m_done = 1;
    settle();
    chk("cfl_err_after", 32'(bus_p.err), 32'd1);
    chk("cfl_d_done", 32'(bus_p.d_done), 32'd1);
    tick();
    bus_p.m_done = 0; bus_p.d_rd = 0; bus_p.d_wr = 0;
    tick();
  endtask

  task automatic test_err_sticky();
    apply_reset();
    settle();
    chk("err_cleared", 32'(bus_p.err), 32'd0);
    tick();
    bus_p.m_err = 1;
    tick();
    bus_p.m_err = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("err_sticky", 32'(bus_p.err), 32'd1);
      tick();
    end
    apply_reset();
    settle();
    chk("err_rst_clear", 32'(bus_p.err), 32'd0);
  endtask

  task automatic test_reset_mid();
    tick();
    bus_p.m_err = 1;
    tick();
    bus_p.m_err = 0;
    bus_p.d_rd = 1; bus_p.d_addr = 16'h0300;
    settle();
    chk("rmid_c0_m_rd", 32'(bus_p.m_rd), 32'd1);
    chk("rmid_c0_err", 32'(bus_p.err), 32'd1);
    tick();
    rst = 1;
    settle();
    chk("rmid_c1_busy_m_addr", 32'(bus_p.m_addr), 32'h0300);
    tick();
    rst = 0; bus_p.d_rd = 0; bus_p.m_done = 1; bus_p.m_rdata = 16'h7777;
    settle();
    chk("rmid_c2_m_rd", 32'(bus_p.m_rd), 32'd0);
    chk("rmid_c2_m_wr", 32'(bus_p.m_wr), 32'd0);
    chk("rmid_c2_err", 32'(bus_p.err), 32'd0);
    chk("rmid_c2_d_done", 32'(bus_p.d_done), 32'd0);
    tick();
    bus_p.m_done = 0; bus_p.m_rdata = '0;
    bus_p.i_req = 1; bus_p.i_addr = 16'h0008;
    settle();
    chk("rmid_c3_idle_m_rd", 32'(bus_p.m_rd), 32'd1);
    chk("rmid_c3_idle_m_addr", 32'(bus_p.m_addr), 32'h0008);
    tick();
    bus_p.m_done = 1;
    settle();
    chk("rmid_c4_i_done", 32'(bus_p.i_done), 32'd1);
    tick();
    bus_p.m_done = 0; bus_p.i_req = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic is_d;
    logic [15:0] exp_addr;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      is_d     = (k % 2 == 0);
      exp_addr = is_d ? 16'h0100 : 16'h0002;
      if (k != 0) tick();
      bus_r.d_wr = 1; bus_r.d_addr = 16'h0100; bus_r.d_wdata = 16'h1234;
      bus_r.i_req = 1; bus_r.i_addr = 16'h0002;
      settle();
      chk("rr_issue_addr", 32'(bus_r.m_addr), 32'(exp_addr));
      chk("rr_issue_wr", 32'(bus_r.m_wr), 32'(is_d));
      tick();
      bus_r.m_done = 1; bus_r.m_rdata = 16'h00C0 + 16'(k);
      settle();
      chk("rr_d_done", 32'(bus_r.d_done), 32'(is_d));
      chk("rr_i_done", 32'(bus_r.i_done), 32'(!is_d));
      tick();
      bus_r.m_done = 0; bus_r.m_rdata = '0;
      settle();
      chk("rr_gap_stalls", 32'({bus_r.i_stall, bus_r.d_stall}), 32'd3);
    end
    tick();
    bus_r.d_wr = 0; bus_r.i_req = 0;
    tick();
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst      = 1;
    clear_inputs();
    test_reset();
    test_fetch_alone();
    test_priority();
    test_abandon();
    test_conflict();
    test_err_sticky();
    test_reset_mid();
    test_round_robin();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
